scan_mod_counter: RTL
=====================

Name: scan_mod_counter

Overview:
Parametrised modulo-N up/down counter with a built-in prescaler, synchronous load/clear, wrap or saturate mode, and a terminal-count pulse. It replaces the fixed free-running 2-bit display-scan counter. It drives the digit index and active-low digit selects for the PS/2 key-code display multiplexer. It can also serve as a frame bit counter in the PS/2 receive path (MODULUS=11, PRESCALE=1).

Parameters:
WIDTH, 4, counter register width in bits; MODULUS <= 2**WIDTH.
MODULUS, 4, count range 0..MODULUS-1; must be >= 2.
PRESCALE, 1, enabled clocks per count step; 1 means step on every enabled clock; must be >= 1.
SATURATE, 0, 0 means wrap at the range ends; 1 means hold at the range ends.
OUT_BITS, 2, width of the z index output; OUT_BITS <= WIDTH.

Ports:
clk       in   1          system clock; all state is updated on the rising edge
clear     in   1          asynchronous active-high reset
en        in   1          count enable; gates both the prescaler and the step
up_dn     in   1          1 = count up, 0 = count down; sampled on each step
sync_clr  in   1          synchronous clear of the count and the prescaler
load      in   1          synchronous load of load_val
load_val  in   WIDTH      value to load; values >= MODULUS are clamped to MODULUS-1
count     out  WIDTH      registered count value
z         out  OUT_BITS   count[OUT_BITS-1:0]
sel_n     out  MODULUS    registered active-low one-hot select; sel_n[i]=0 iff count==i
tick      out  1          registered; high for 1 cycle after each count step
tc        out  1          registered; high for 1 cycle after a step taken at the terminal value

Behaviour:
- Clock and reset: single clock clk. Reset is clear: asynchronous, active-high.
- Reset values while clear=1: count=0, prescaler=0, tick=0, tc=0, sel_n = all ones except bit0=0.
- Priority, evaluated each rising edge: clear (async) > sync_clr > load > step.
- sync_clr: count<=0 and prescaler<=0; tick and tc <=0. Independent of en.
- load: count<=min(load_val, MODULUS-1) and prescaler<=0; tick and tc <=0. Independent of en.
- Prescaler: internal counter of width clog2(PRESCALE), at least 1 bit.
  - While en=1 it counts 0..PRESCALE-1 and wraps.
  - step = en && (prescaler==PRESCALE-1).
  - While en=0 the prescaler and count hold; tick and tc drop to 0 on the next edge.
- Terminal value: MODULUS-1 when up_dn=1, 0 when up_dn=0.
- On step, count moves as follows:
  - Up, not at terminal: count+1.
  - Up, at terminal: 0 if SATURATE=0, hold if SATURATE=1.
  - Down, not at terminal: count-1.
  - Down, at terminal: MODULUS-1 if SATURATE=0, hold if SATURATE=1.
- Arithmetic is exact within the range; there is no binary rollover through 2**WIDTH when MODULUS < 2**WIDTH.
- Output latency, all measured from the edge on which step is taken:
  - tick <= step, so it is valid 1 cycle later, together with the new count.
  - tc <= step && (count==terminal). It pulses in saturate mode as well, once per attempted step at the end.
  - sel_n is decoded from the next count value and registered, so it always matches count in the same cycle.
- up_dn changes between steps take effect on the next step; the prescaler phase is preserved.
- Reset mid-operation: all state is lost immediately; counting restarts from 0 with a full PRESCALE interval.
- Illegal parameters (MODULUS > 2**WIDTH, MODULUS < 2, PRESCALE < 1, OUT_BITS > WIDTH) are rejected by elaboration-time checks.

Decomposition:
- Shared package counter_pkg:
  - clog2 constant function.
  - DIR_DOWN=0 and DIR_UP=1 constants.
  - MODE_WRAP=0 and MODE_SAT=1 constants.
- Sub-module tick_prescaler, parameter PRESCALE:
  - Ports: clk, clear, en, restart, tick_en.
  - restart is driven by sync_clr|load; tick_en is the combinational step.
  - When PRESCALE=1 it reduces to tick_en=en.
- The top level holds the count register, next-value logic, clamp, sel_n decode and output registers.

Test Plan:
1. Defaults (W=4, M=4, P=1, wrap); release clear; en=1, up_dn=1 for 6 clocks -> count 1,2,3,0,1,2; tc high only in the cycle count becomes 0; sel_n=4'b1110 when count=0.
2. Down wrap (M=10) from count=0 with one step -> count=9, tc=1 for 1 cycle; second step -> count=8, tc=0.
3. Saturate (M=5, SATURATE=1): count up to 4, then 3 more steps -> count stays 4, tc pulses on each attempted step; switch up_dn=0 and step -> count=3, tc=0.
4. Prescaler (P=3): en=1 continuously -> count increments every 3rd clock, tick high 1 of every 3 cycles; en=0 for 2 cycles mid-interval then en=1 -> phase resumes and the step is delayed exactly 2 cycles.
5. Priority: load=1, load_val=13 with M=10 -> count=9; same cycle sync_clr=1 and load=1 -> count=0; load while en=0 -> loaded and held.
6. Async clear asserted between clock edges while count=2 and prescaler mid-interval -> count=0 and sel_n=...1110 immediately, without a clock edge; after release the first step comes exactly PRESCALE enabled clocks later.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo counter and its prescaler.
package counter_pkg;

   localparam logic DIR_DOWN = 1'b0;
   localparam logic DIR_UP   = 1'b1;

   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   // Per-edge action chosen by the priority decode in the top level.
   typedef enum logic [1:0] {
      OP_HOLD = 2'd0,
      OP_CLR  = 2'd1,
      OP_LOAD = 2'd2,
      OP_STEP = 2'd3
   } count_op_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled clocks by PRESCALE; tick_en is the combinational step strobe.
module tick_prescaler
   import counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic clear,
   input  logic en,
   input  logic restart,
   output logic tick_en
);

   if (PRESCALE < 1) begin : g_bad_prescale
      $error("tick_prescaler: PRESCALE must be >= 1");
   end

   if (PRESCALE == 1) begin : g_bypass
      logic w_unused;
      assign w_unused = clk | clear | restart;
      assign tick_en  = en;
   end else begin : g_divide
      localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] r_phase;
      logic          w_last;

      assign w_last  = (r_phase == LAST);
      assign tick_en = en && w_last;

      // Phase only advances on enabled clocks, so en=0 freezes it mid-interval.
      always_ff @(posedge clk or posedge clear) begin
         if (clear) begin
            r_phase <= '0;
         end else if (restart) begin
            r_phase <= '0;
         end else if (en) begin
            r_phase <= w_last ? '0 : r_phase + 1'b1;
         end
      end
   end

endmodule

// File: rtl/scan_mod_counter.sv
// Modulo-N up/down counter with prescaler, load/clear, wrap or saturate,
// terminal-count pulse and registered active-low one-hot digit select.
module scan_mod_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 4,
   parameter int PRESCALE = 1,
   parameter int SATURATE = 0,
   parameter int OUT_BITS = 2
) (
   input  logic                clk,
   input  logic                clear,
   input  logic                en,
   input  logic                up_dn,
   input  logic                sync_clr,
   input  logic                load,
   input  logic [WIDTH-1:0]    load_val,
   output logic [WIDTH-1:0]    count,
   output logic [OUT_BITS-1:0] z,
   output logic [MODULUS-1:0]  sel_n,
   output logic                tick,
   output logic                tc
);

   if (longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_mod_w
      $error("scan_mod_counter: MODULUS must be <= 2**WIDTH");
   end
   if (MODULUS < 2) begin : g_bad_mod
      $error("scan_mod_counter: MODULUS must be >= 2");
   end
   if (PRESCALE < 1) begin : g_bad_pre
      $error("scan_mod_counter: PRESCALE must be >= 1");
   end
   if (OUT_BITS > WIDTH) begin : g_bad_out
      $error("scan_mod_counter: OUT_BITS must be <= WIDTH");
   end

   localparam logic [WIDTH-1:0]   MAX_VAL   = WIDTH'(MODULUS - 1);
   localparam logic [MODULUS-1:0] SEL_RESET = {{(MODULUS-1){1'b1}}, 1'b0};

   logic [WIDTH-1:0]   r_count;
   logic [MODULUS-1:0] r_sel_n;
   logic               r_tick;
   logic               r_tc;

   logic               w_step;
   logic               w_up;
   count_op_e          w_op;
   logic [WIDTH-1:0]   w_clamped;
   logic [WIDTH-1:0]   w_term;
   logic               w_at_term;
   logic [WIDTH-1:0]   w_stepped;
   logic [WIDTH-1:0]   w_next_count;
   logic [MODULUS-1:0] w_next_sel_n;
   logic               w_next_tick;
   logic               w_next_tc;

   tick_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_prescaler (
      .clk    (clk),
      .clear  (clear),
      .en     (en),
      .restart(sync_clr | load),
      .tick_en(w_step)
   );

   assign w_up = (up_dn == DIR_UP);

   always_comb begin
      w_op = OP_HOLD;
      if (sync_clr) begin
         w_op = OP_CLR;
      end else if (load) begin
         w_op = OP_LOAD;
      end else if (w_step) begin
         w_op = OP_STEP;
      end
   end

   assign w_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
   assign w_term    = w_up ? MAX_VAL : '0;
   assign w_at_term = (r_count == w_term);

   // The terminal check keeps +1/-1 from ever leaving 0..MODULUS-1.
   always_comb begin
      w_stepped = r_count;
      if (w_at_term) begin
         if (SATURATE != MODE_SAT) begin
            w_stepped = w_up ? '0 : MAX_VAL;
         end
      end else begin
         w_stepped = w_up ? r_count + 1'b1 : r_count - 1'b1;
      end
   end

   always_comb begin
      w_next_count = r_count;
      w_next_tick  = 1'b0;
      w_next_tc    = 1'b0;
      case (w_op)
         OP_CLR:  w_next_count = '0;
         OP_LOAD: w_next_count = w_clamped;
         OP_STEP: begin
            w_next_count = w_stepped;
            w_next_tick  = 1'b1;
            w_next_tc    = w_at_term;
         end
         default: w_next_count = r_count;
      endcase
   end

   // Decode from the next value so sel_n lines up with count in the same cycle.
   always_comb begin
      w_next_sel_n = '1;
      for (int i = 0; i < MODULUS; i++) begin
         w_next_sel_n[i] = (w_next_count != WIDTH'(i));
      end
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_count <= '0;
         r_sel_n <= SEL_RESET;
         r_tick  <= 1'b0;
         r_tc    <= 1'b0;
      end else begin
         r_count <= w_next_count;
         r_sel_n <= w_next_sel_n;
         r_tick  <= w_next_tick;
         r_tc    <= w_next_tc;
      end
   end

   assign count = r_count;
   assign z     = r_count[OUT_BITS-1:0];
   assign sel_n = r_sel_n;
   assign tick  = r_tick;
   assign tc    = r_tc;

endmodule
